io_word_serializer: RTL and testbench

- Sits directly downstream of the generic I/O FIFO and drains its DATA_WIDTH-wide words.
- Splits each word into OUT_WIDTH-wide beats for a narrow peripheral port (e.g. UART/SPI byte sink).
- Marks the final beat of every word with last.
- Number of beats per word is selectable per word, so partial words can be sent.

---
 rtl/io_word_serializer.sv | 164 ++++++++++++++++
 tb/tb_io_word_serializer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_word_serializer.sv
// io_word_serializer
// Drains IN_WIDTH-wide words from an upstream FIFO and replays each one as a
// sequence of OUT_WIDTH-wide beats on a narrow valid/ready port. The final beat
// of every word carries out_last_o. Each word can request fewer beats than
// RATIO, so partial words can be sent. A new word is popped in the same cycle
// as the final beat of the previous one, so back-to-back words have no bubble.

module io_word_serializer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter int RATIO     = IN_WIDTH / OUT_WIDTH,
  parameter int LOG_RATIO = $clog2(RATIO),
  parameter int MSB_FIRST = 0
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clr_i,
  input  logic [IN_WIDTH-1:0]  in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [LOG_RATIO:0]   beats_i,
  output logic [OUT_WIDTH-1:0] out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 out_last_o,
  output logic                 busy_o
);

  // A zero-width counter is not legal, so RATIO==1 still gets a 1-bit counter
  // that simply never leaves 0.
  localparam int CNT_W = (LOG_RATIO > 0) ? LOG_RATIO : 1;
  // Beat-count width: large enough to hold RATIO itself.
  localparam int NB_W  = LOG_RATIO + 1;

  typedef enum logic {
    IDLE  = 1'b0,  // no word held
    SHIFT = 1'b1   // word held, beats pending
  } state_e;

  state_e state_q, state_d;

  // Held word viewed as RATIO slices of OUT_WIDTH bits, slice 0 = bits [OUT_WIDTH-1:0].
  logic [RATIO-1:0][OUT_WIDTH-1:0] word_q, word_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [NB_W-1:0]                 num_beats_q, num_beats_d;

  logic [CNT_W-1:0] slice_idx;
  logic [NB_W-1:0]  beats_clamped;
  logic             last_beat;
  logic             beat_fire;
  logic             accept;

  // ---------------------------------------------------------------------------
  // Handshake terms shared by the FSM and the datapath
  // ---------------------------------------------------------------------------
  assign beat_fire = (state_q == SHIFT) && out_ready_i;
  assign accept    = in_valid_i && in_ready_o;

  // Current beat is the final one of its word when the counter reaches num_beats-1.
  assign last_beat = (NB_W'(cnt_q) == (num_beats_q - NB_W'(1)));

  // Requested beat count, with 0 and out-of-range requests meaning "whole word".
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default on entry so no
    // path leaves it unassigned, which would otherwise infer a latch.
    beats_clamped = beats_i;
    if ((beats_i == '0) || (beats_i > NB_W'(RATIO))) begin
      beats_clamped = NB_W'(RATIO);
    end
  end

  // Map the beat counter to the slice being presented, honouring bit order.
  always_comb begin
    slice_idx = cnt_q;
    if (MSB_FIRST != 0) begin
      slice_idx = CNT_W'(RATIO - 1) - cnt_q;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // State register with asynchronous reset to IDLE.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      // NOTE: sequential state is always updated with non-blocking assignments
      // so every register samples pre-edge values regardless of block order.
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // Clear wins over everything; otherwise move on accept / final beat.
  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) state_d = SHIFT;
        end
        SHIFT: begin
          // Final beat leaves: reload in place if a new word arrives, else idle.
          if (beat_fire && last_beat) state_d = accept ? SHIFT : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // Beat presentation and the pop strobe towards the FIFO. in_ready_o depends
  // combinationally on out_ready_i so the next word is taken on the final beat.
  always_comb begin
    out_valid_o = (state_q == SHIFT);
    busy_o      = (state_q == SHIFT);
    out_last_o  = (state_q == SHIFT) && last_beat;
    out_data_o  = word_q[slice_idx];
    in_ready_o  = rstn_i && !clr_i &&
                  ((state_q == IDLE) || ((state_q == SHIFT) && out_ready_i && last_beat));
  end

  // ---------------------------------------------------------------------------
  // Datapath: held word, beat counter, beat count
  // ---------------------------------------------------------------------------
  // Load on accept, advance on each non-final beat, rewind on clear.
  always_comb begin
    word_d      = word_q;
    cnt_d       = cnt_q;
    num_beats_d = num_beats_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (accept) begin
      word_d      = in_data_i;
      cnt_d       = '0;
      num_beats_d = beats_clamped;
    end else if (beat_fire && !last_beat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      // NOTE: the held word is reset, not left undefined, because out_data_o
      // is read straight from it and must come up as zero.
      word_q      <= '0;
      cnt_q       <= '0;
      num_beats_q <= '0;
    end else begin
      word_q      <= word_d;
      cnt_q       <= cnt_d;
      num_beats_q <= num_beats_d;
    end
  end

endmodule

// File: tb/tb_io_word_serializer.sv
// Bench for io_word_serializer: two instances (LSB-first and MSB-first) share
// one stimulus. A queue-based model of expected beats is checked against both
// on every falling edge; directed scenarios also pin exact beat sequences.

module tb_io_word_serializer;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [2:0]  beats = '0;
  logic        out_ready = 1'b0;

  logic       lsb_in_ready, lsb_valid, lsb_last, lsb_busy;
  logic [7:0] lsb_data;
  logic       msb_in_ready, msb_valid, msb_last, msb_busy;
  logic [7:0] msb_data;

  // Sink-ready control: either a fixed level or a toggle every cycle.
  bit ready_l = 1'b1;
  bit tog_en  = 1'b0;

  int checks = 0;
  int errors = 0;

  io_word_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk_i(clk), .rstn_i(rstn), .clr_i(clr),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(lsb_in_ready),
    .beats_i(beats),
    .out_data_o(lsb_data), .out_valid_o(lsb_valid), .out_ready_i(out_ready),
    .out_last_o(lsb_last), .busy_o(lsb_busy)
  );

  io_word_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1)) dut_msb (
    .clk_i(clk), .rstn_i(rstn), .clr_i(clr),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(msb_in_ready),
    .beats_i(beats),
    .out_data_o(msb_data), .out_valid_o(msb_valid), .out_ready_i(out_ready),
    .out_last_o(msb_last), .busy_o(msb_busy)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: pending beats of the current word as {last, data}, head = on the wire
  // ---------------------------------------------------------------------------
  logic [8:0] q_lsb[$];
  logic [8:0] q_msb[$];
  bit         m_acc = 1'b0;
  bit         m_rdy_now;
  int         cyc = 0;
  int         acc_cyc = 0;
  int         n_beats;

  // The FIFO may pop when nothing is held, or when the held word's last beat leaves now.
  function automatic bit m_ready();
    return rstn && !clr && ((q_lsb.size() == 0) || ((q_lsb.size() == 1) && out_ready));
  endfunction

  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      q_lsb.delete();
      q_msb.delete();
      m_acc = 1'b0;
    end else begin
      m_acc = 1'b0;
      if (clr) begin
        q_lsb.delete();
        q_msb.delete();
      end else begin
        m_rdy_now = m_ready();
        if ((q_lsb.size() > 0) && out_ready) begin
          void'(q_lsb.pop_front());
          void'(q_msb.pop_front());
        end
        if (in_valid && m_rdy_now) begin
          m_acc   = 1'b1;
          acc_cyc = cyc;
          n_beats = ((int'(beats) == 0) || (int'(beats) > R)) ? R : int'(beats);
          for (int k = 0; k < n_beats; k++) begin
            q_lsb.push_back({k == n_beats - 1, in_data[8*k +: 8]});
            q_msb.push_back({k == n_beats - 1, in_data[8*(R-1-k) +: 8]});
          end
        end
      end
      cyc++;
    end
  end

  // Sink-ready driver, a little after the active edge.
  initial forever begin
    @(posedge clk);
    #2;
    out_ready = tog_en ? ~out_ready : ready_l;
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare plus a log of beats that actually transferred
  // ---------------------------------------------------------------------------
  logic [8:0] log_lsb[$];
  logic [8:0] log_msb[$];
  int         log_cyc[$];

  task automatic compare_port(input string tag, input logic v, input logic l,
                              input logic [7:0] d, input logic b, input logic rdy,
                              input logic [8:0] head, input bit have);
    check({tag, "_valid"},    32'(v),   32'(have));
    check({tag, "_busy"},     32'(b),   32'(have));
    check({tag, "_last"},     32'(l),   have ? 32'(head[8]) : 32'd0);
    check({tag, "_in_ready"}, 32'(rdy), 32'(m_ready()));
    if (have) check({tag, "_data"}, 32'(d), 32'(head[7:0]));
  endtask

  initial forever begin
    @(negedge clk);
    compare_port("lsb", lsb_valid, lsb_last, lsb_data, lsb_busy, lsb_in_ready,
                 (q_lsb.size() > 0) ? q_lsb[0] : 9'h0, q_lsb.size() > 0);
    compare_port("msb", msb_valid, msb_last, msb_data, msb_busy, msb_in_ready,
                 (q_msb.size() > 0) ? q_msb[0] : 9'h0, q_msb.size() > 0);
    if (lsb_valid && out_ready) begin
      log_lsb.push_back({lsb_last, lsb_data});
      log_cyc.push_back(cyc);
    end
    if (msb_valid && out_ready) log_msb.push_back({msb_last, msb_data});
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic push_word(input logic [31:0] w, input logic [2:0] b);
    int i;
    in_data  = w;
    beats    = b;
    in_valid = 1'b1;
    i = 0;
    do begin
      @(posedge clk);
      #1;
      i++;
    end while (!m_acc && (i < 64));
    in_valid = 1'b0;
    check("word_accepted", 32'(m_acc), 32'd1);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((q_lsb.size() != 0) && (i < 64)) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("idle_lsb_busy", 32'(lsb_busy), 32'd0);
    check("idle_msb_busy", 32'(msb_busy), 32'd0);
  endtask

  task automatic clear_logs();
    log_lsb.delete();
    log_msb.delete();
    log_cyc.delete();
  endtask

  // Compare a log against literal beats: beat i is data[8*i +: 8], last flag lastm[i].
  task automatic check_log(input string name, input bit msb, input int n,
                           input logic [63:0] data, input logic [7:0] lastm);
    logic [8:0] lg[$];
    if (msb) lg = log_msb;
    else     lg = log_lsb;
    check({name, "_len"}, 32'(lg.size()), 32'(n));
    for (int i = 0; (i < n) && (i < lg.size()); i++) begin
      check(name, 32'(lg[i]), 32'({lastm[i], data[8*i +: 8]}));
    end
  endtask

  // Beats must land on consecutive cycles starting right after the accept.
  task automatic check_contig(input string name, input int first_acc, input int n);
    check({name, "_len"}, 32'(log_cyc.size()), 32'(n));
    for (int i = 0; (i < n) && (i < log_cyc.size()); i++) begin
      check(name, 32'(log_cyc[i]), 32'(first_acc + 1 + i));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  int first_acc;

  initial begin
    #1;
    check("rst_lsb_valid",    32'(lsb_valid),    32'd0);
    check("rst_lsb_last",     32'(lsb_last),     32'd0);
    check("rst_lsb_data",     32'(lsb_data),     32'd0);
    check("rst_lsb_busy",     32'(lsb_busy),     32'd0);
    check("rst_lsb_in_ready", 32'(lsb_in_ready), 32'd0);
    check("rst_msb_data",     32'(msb_data),     32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #3;

    // 1: whole word, beats_i=0, sink always ready.
    clear_logs();
    push_word(32'hA1B2C3D4, 3'd0);
    first_acc = acc_cyc;
    wait_idle();
    check_log("s1_lsb", 1'b0, 4, 64'hA1B2C3D4, 8'b0000_1000);
    check_log("s1_msb", 1'b1, 4, 64'hD4C3B2A1, 8'b0000_1000);
    check_contig("s1_cyc", first_acc, 4);

    // 2: two words back to back, no idle cycle between them.
    clear_logs();
    push_word(32'h11223344, 3'd4);
    first_acc = acc_cyc;
    push_word(32'h55667788, 3'd4);
    wait_idle();
    check_log("s2_lsb", 1'b0, 8, 64'h55667788_11223344, 8'b1000_1000);
    check_log("s2_msb", 1'b1, 8, 64'h88776655_44332211, 8'b1000_1000);
    check_contig("s2_cyc", first_acc, 8);

    // 3: partial word, two beats.
    clear_logs();
    push_word(32'hDEADBEEF, 3'd2);
    wait_idle();
    check_log("s3_msb", 1'b1, 2, 64'hADDE, 8'b0000_0010);
    check_log("s3_lsb", 1'b0, 2, 64'hBEEF, 8'b0000_0010);

    // 4: sink toggles; the next word waits until the final handshake.
    clear_logs();
    tog_en = 1'b1;
    push_word(32'h01020304, 3'd0);
    push_word(32'h0A0B0C0D, 3'd4);
    wait_idle();
    tog_en  = 1'b0;
    ready_l = 1'b1;
    @(posedge clk);
    #3;
    check_log("s4_lsb", 1'b0, 8, 64'h0A0B0C0D_01020304, 8'b1000_1000);
    check_log("s4_msb", 1'b1, 8, 64'h0D0C0B0A_04030201, 8'b1000_1000);

    // 5: beats_i above RATIO is clamped to a whole word.
    clear_logs();
    push_word(32'hCAFEF00D, 3'd7);
    wait_idle();
    check_log("s5_lsb", 1'b0, 4, 64'hCAFEF00D, 8'b0000_1000);
    check_log("s5_msb", 1'b1, 4, 64'h0DF0FECA, 8'b0000_1000);

    // 6: clear after two beats with the next word already offered.
    clear_logs();
    push_word(32'h12345678, 3'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    ready_l  = 1'b0;
    clr      = 1'b1;
    in_data  = 32'h9ABCDEF0;
    beats    = 3'd0;
    in_valid = 1'b1;
    #4;
    check("s6_no_pop_in_clr", 32'(lsb_in_ready), 32'd0);
    @(posedge clk);
    #1;
    clr     = 1'b0;
    ready_l = 1'b1;
    check("s6_valid_after_clr", 32'(lsb_valid), 32'd0);
    check("s6_busy_after_clr",  32'(lsb_busy),  32'd0);
    push_word(32'h9ABCDEF0, 3'd0);
    wait_idle();
    check_log("s6_lsb", 1'b0, 6, 64'h0000_9ABCDEF0_5678, 8'b0010_0000);
    check_log("s6_msb", 1'b1, 6, 64'h0000_F0DEBC9A_3412, 8'b0010_0000);

    // 7: asynchronous reset mid-word.
    clear_logs();
    push_word(32'h55AA33CC, 3'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    rstn = 1'b0;
    #1;
    check("s7_lsb_valid",    32'(lsb_valid),    32'd0);
    check("s7_lsb_last",     32'(lsb_last),     32'd0);
    check("s7_lsb_data",     32'(lsb_data),     32'd0);
    check("s7_lsb_busy",     32'(lsb_busy),     32'd0);
    check("s7_lsb_in_ready", 32'(lsb_in_ready), 32'd0);
    check("s7_msb_valid",    32'(msb_valid),    32'd0);
    check("s7_msb_data",     32'(msb_data),     32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();
    push_word(32'hCAFEF00D, 3'd0);
    wait_idle();
    check_log("s7_lsb", 1'b0, 4, 64'hCAFEF00D, 8'b0000_1000);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
